game_sequencer: RTL and testbench

Round-level controller for the memory-tester game. It gates the player session on authentication and starts each flash/answer round. It consumes the win/loose/timeout verdicts from the game datapath and advances the level number it drives back into that datapath. It also keeps lives and score, sits directly above the game module and below the top-level display/button logic, and owns the only writable copy of the current level.

---
 rtl/game_sequencer_if.sv | 32 +++
 rtl/game_sequencer.sv | 164 ++++++++++++++++
 tb/tb_game_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Control and status bundle between the round sequencer and its neighbours.
// master is the sequencer side; slave is the datapath/display side.
interface game_sequencer_if;
    logic       auth_bit;
    logic       logout;
    logic       button_pulse;
    logic       win;
    logic       loose;
    logic       time_stop;
    logic [3:0] level_num;
    logic       levelupdated;
    logic       round_start;
    logic       round_abort;
    logic       game_enable;
    logic [1:0] lives;
    logic [7:0] score;
    logic       game_over;
    logic       champion;
    logic [2:0] state;

    modport master (
        input  auth_bit, logout, button_pulse, win, loose, time_stop,
        output level_num, levelupdated, round_start, round_abort, game_enable,
        output lives, score, game_over, champion, state
    );

    modport slave (
        output auth_bit, logout, button_pulse, win, loose, time_stop,
        input  level_num, levelupdated, round_start, round_abort, game_enable,
        input  lives, score, game_over, champion, state
    );
endinterface

// File: rtl/game_sequencer.sv
// Round-level controller for the memory-tester game: session gating, round launch,
// verdict handling, level/lives/score bookkeeping and inter-round cooldown.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | not authenticated, waiting for auth_bit
// READY     | authenticated, waiting for button_pulse to start a round
// PLAY      | round running, waiting for a verdict
// WIN       | one cycle: credit score, advance level or crown champion
// LOSE      | one cycle: take a life, maybe end the game
// COOLDOWN  | pause down-counter running before next READY
// GAME_OVER | lives exhausted, button_pulse restarts the game
// CHAMPION  | MAX_LEVEL cleared, button_pulse restarts the game
module game_sequencer #(
    parameter int unsigned MAX_LEVEL    = 9,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned PAUSE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              rst,
    game_sequencer_if.master  bus
);

    localparam int unsigned CW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD   = CW'(PAUSE_CYCLES - 1);
    localparam logic [3:0]    LVL_MAX    = 4'(MAX_LEVEL);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READY     = 3'd1,
        PLAY      = 3'd2,
        WIN       = 3'd3,
        LOSE      = 3'd4,
        COOLDOWN  = 3'd5,
        GAME_OVER = 3'd6,
        CHAMPION  = 3'd7
    } state_t;

    state_t        state_r, state_nx;
    logic [3:0]    level_r, level_nx;
    logic [1:0]    lives_r, lives_nx;
    logic [7:0]    score_r, score_nx;
    logic [CW-1:0] cnt_r, cnt_nx;
    logic          start_r, start_nx;
    logic          lvlup_r, lvlup_nx;
    logic          abort_r, abort_nx;
    logic          enable_r, over_r, champ_r;
    logic          kill;
    logic [8:0]    score_sum;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            level_r  <= 4'd1;
            lives_r  <= LIVES_INIT;
            score_r  <= 8'd0;
            cnt_r    <= '0;
            start_r  <= 1'b0;
            lvlup_r  <= 1'b0;
            abort_r  <= 1'b0;
            enable_r <= 1'b0;
            over_r   <= 1'b0;
            champ_r  <= 1'b0;
        end else begin
            state_r  <= state_nx;
            level_r  <= level_nx;
            lives_r  <= lives_nx;
            score_r  <= score_nx;
            cnt_r    <= cnt_nx;
            start_r  <= start_nx;
            lvlup_r  <= lvlup_nx;
            abort_r  <= abort_nx;
            enable_r <= (state_nx == PLAY);
            over_r   <= (state_nx == GAME_OVER);
            champ_r  <= (state_nx == CHAMPION);
        end
    end

    // Losing auth outside IDLE is treated exactly like an explicit logout.
    assign kill      = bus.logout || ((state_r != IDLE) && !bus.auth_bit);
    assign score_sum = {1'b0, score_r} + {5'd0, level_r};

    always_comb begin
        state_nx = state_r;
        level_nx = level_r;
        lives_nx = lives_r;
        score_nx = score_r;
        cnt_nx   = cnt_r;
        start_nx = 1'b0;
        lvlup_nx = 1'b0;
        abort_nx = 1'b0;

        if (kill) begin
            state_nx = IDLE;
            level_nx = 4'd1;
            lives_nx = LIVES_INIT;
            score_nx = 8'd0;
            abort_nx = (state_r == PLAY);
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.auth_bit) state_nx = READY;
                end
                READY: begin
                    if (bus.button_pulse) begin
                        state_nx = PLAY;
                        start_nx = 1'b1;
                    end
                end
                PLAY: begin
                    if (bus.loose || bus.time_stop) state_nx = LOSE;
                    else if (bus.win)               state_nx = WIN;
                end
                WIN: begin
                    score_nx = score_sum[8] ? 8'hFF : score_sum[7:0];
                    if (level_r >= LVL_MAX) begin
                        state_nx = CHAMPION;
                    end else begin
                        level_nx = level_r + 4'd1;
                        lvlup_nx = 1'b1;
                        cnt_nx   = CNT_LOAD;
                        state_nx = COOLDOWN;
                    end
                end
                LOSE: begin
                    if (lives_r <= 2'd1) begin
                        lives_nx = 2'd0;
                        state_nx = GAME_OVER;
                    end else begin
                        lives_nx = lives_r - 2'd1;
                        cnt_nx   = CNT_LOAD;
                        state_nx = COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (cnt_r == '0) state_nx = READY;
                    else             cnt_nx   = cnt_r - 1'b1;
                end
                GAME_OVER, CHAMPION: begin
                    if (bus.button_pulse) begin
                        state_nx = READY;
                        level_nx = 4'd1;
                        lives_nx = LIVES_INIT;
                        score_nx = 8'd0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign bus.state        = state_r;
    assign bus.level_num    = level_r;
    assign bus.lives        = lives_r;
    assign bus.score        = score_r;
    assign bus.round_start  = start_r;
    assign bus.levelupdated = lvlup_r;
    assign bus.round_abort  = abort_r;
    assign bus.game_enable  = enable_r;
    assign bus.game_over    = over_r;
    assign bus.champion     = champ_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a cycle table for login/first round/cooldown,
// then hand-written sequences for the win ladder, lives, logout and reset.
module tb_game_sequencer;

    logic clock;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    game_sequencer_if bus ();

    game_sequencer #(
        .MAX_LEVEL    (9),
        .LIVES        (3),
        .PAUSE_CYCLES (16)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       auth, lo, btn, w, l, t;
        int         reps;
        logic [2:0] st;
        logic [3:0] lvl;
        logic [1:0] lv;
        logic [7:0] sc;
        logic       rs, lu, ra, ge;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic a, input logic lo, input logic b,
                        input logic w, input logic l, input logic t);
        @(negedge clock);
        bus.auth_bit     = a;
        bus.logout       = lo;
        bus.button_pulse = b;
        bus.win          = w;
        bus.loose        = l;
        bus.time_stop    = t;
        @(posedge clock);
        #1;
    endtask

    // Steps with idle inputs until READY; checks cycle count and that no level pulse fires.
    task automatic wait_ready(input string nm, input int exp_n);
        int n;
        int lu_seen;
        n = 0;
        lu_seen = 0;
        do begin
            step(1, 0, 0, 0, 0, 0);
            n++;
            lu_seen += int'(bus.levelupdated);
        end while (bus.state != 3'd1 && n < 40);
        chk({nm, " cooldown cycles"}, n, exp_n);
        chk({nm, " cooldown levelupdated"}, lu_seen, 0);
    endtask

    task automatic win_round(input int lvl, input int sc_before);
        step(1, 0, 1, 0, 0, 0);
        chk($sformatf("win L%0d round_start", lvl), int'(bus.round_start), 1);
        chk($sformatf("win L%0d play state", lvl), int'(bus.state), 2);
        step(1, 0, 0, 1, 0, 0);
        chk($sformatf("win L%0d win state", lvl), int'(bus.state), 3);
        step(1, 0, 0, 0, 0, 0);
        chk($sformatf("win L%0d cooldown state", lvl), int'(bus.state), 5);
        chk($sformatf("win L%0d levelupdated", lvl), int'(bus.levelupdated), 1);
        chk($sformatf("win L%0d level", lvl), int'(bus.level_num), lvl + 1);
        chk($sformatf("win L%0d score", lvl), int'(bus.score), sc_before + lvl);
        wait_ready($sformatf("win L%0d", lvl), 16);
    endtask

    task automatic lose_round(input string nm, input logic l, input logic t, input int lives_before);
        step(1, 0, 1, 0, 0, 0);
        chk({nm, " play state"}, int'(bus.state), 2);
        step(1, 0, 0, 0, l, t);
        chk({nm, " lose state"}, int'(bus.state), 4);
        step(1, 0, 0, 0, 0, 0);
        chk({nm, " lives"}, int'(bus.lives), lives_before - 1);
        chk({nm, " levelupdated"}, int'(bus.levelupdated), 0);
        if (lives_before == 1) begin
            chk({nm, " game_over state"}, int'(bus.state), 6);
            chk({nm, " game_over flag"}, int'(bus.game_over), 1);
        end else begin
            chk({nm, " cooldown state"}, int'(bus.state), 5);
            wait_ready(nm, 16);
        end
    endtask

    initial begin
        int sc;

        tbl[0]  = '{1,0,0,0,0,0,  1, 3'd1, 4'd1, 2'd3, 8'd0, 0,0,0,0};
        tbl[1]  = '{1,0,1,0,0,0,  1, 3'd2, 4'd1, 2'd3, 8'd0, 1,0,0,1};
        tbl[2]  = '{1,0,0,0,0,0,  1, 3'd2, 4'd1, 2'd3, 8'd0, 0,0,0,1};
        tbl[3]  = '{1,0,1,0,0,0,  1, 3'd2, 4'd1, 2'd3, 8'd0, 0,0,0,1};
        tbl[4]  = '{1,0,0,1,1,0,  1, 3'd4, 4'd1, 2'd3, 8'd0, 0,0,0,0};
        tbl[5]  = '{1,0,0,0,0,0,  1, 3'd5, 4'd1, 2'd2, 8'd0, 0,0,0,0};
        tbl[6]  = '{1,0,0,1,0,0,  1, 3'd5, 4'd1, 2'd2, 8'd0, 0,0,0,0};
        tbl[7]  = '{1,0,0,0,0,0,  2, 3'd5, 4'd1, 2'd2, 8'd0, 0,0,0,0};
        tbl[8]  = '{1,0,1,0,0,0,  1, 3'd5, 4'd1, 2'd2, 8'd0, 0,0,0,0};
        tbl[9]  = '{1,0,0,0,0,1, 11, 3'd5, 4'd1, 2'd2, 8'd0, 0,0,0,0};
        tbl[10] = '{1,0,0,0,0,0,  1, 3'd1, 4'd1, 2'd2, 8'd0, 0,0,0,0};

        rst = 1'b0;
        bus.auth_bit = 0; bus.logout = 0; bus.button_pulse = 0;
        bus.win = 0; bus.loose = 0; bus.time_stop = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset state", int'(bus.state), 0);
        chk("reset level", int'(bus.level_num), 1);
        chk("reset lives", int'(bus.lives), 3);
        chk("reset score", int'(bus.score), 0);
        chk("reset outputs", int'({bus.game_enable, bus.game_over, bus.champion,
                                   bus.round_start, bus.levelupdated, bus.round_abort}), 0);
        @(negedge clock);
        rst = 1'b1;

        // Login, first round with coincident win+loose, cooldown with ignored inputs.
        for (int i = 0; i < 11; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(tbl[i].auth, tbl[i].lo, tbl[i].btn, tbl[i].w, tbl[i].l, tbl[i].t);
                chk($sformatf("vec%0d.%0d state", i, r), int'(bus.state), int'(tbl[i].st));
                chk($sformatf("vec%0d.%0d level", i, r), int'(bus.level_num), int'(tbl[i].lvl));
                chk($sformatf("vec%0d.%0d lives", i, r), int'(bus.lives), int'(tbl[i].lv));
                chk($sformatf("vec%0d.%0d score", i, r), int'(bus.score), int'(tbl[i].sc));
                chk($sformatf("vec%0d.%0d pulses", i, r),
                    int'({bus.round_start, bus.levelupdated, bus.round_abort}),
                    int'({tbl[i].rs, tbl[i].lu, tbl[i].ra}));
                chk($sformatf("vec%0d.%0d game_enable", i, r), int'(bus.game_enable), int'(tbl[i].ge));
            end
        end

        // Win ladder to champion.
        sc = 0;
        for (int k = 1; k <= 8; k++) begin
            win_round(k, sc);
            sc += k;
        end
        chk("ladder level", int'(bus.level_num), 9);
        chk("ladder score", int'(bus.score), 36);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        chk("final win state", int'(bus.state), 3);
        step(1, 0, 0, 0, 0, 0);
        chk("champion state", int'(bus.state), 7);
        chk("champion flag", int'(bus.champion), 1);
        chk("champion score", int'(bus.score), 45);
        chk("champion level", int'(bus.level_num), 9);
        chk("champion no levelupdated", int'(bus.levelupdated), 0);
        step(1, 0, 0, 0, 0, 0);
        chk("champion holds", int'(bus.state), 7);
        step(1, 0, 1, 0, 0, 0);
        chk("champion restart state", int'(bus.state), 1);
        chk("champion restart level", int'(bus.level_num), 1);
        chk("champion restart lives", int'(bus.lives), 3);
        chk("champion restart score", int'(bus.score), 0);
        chk("champion restart flag", int'(bus.champion), 0);

        // Lives exhaustion at level 2.
        win_round(1, 0);
        lose_round("timeout", 0, 1, 3);
        lose_round("loose1", 1, 0, 2);
        lose_round("loose2", 1, 0, 1);
        chk("game_over level", int'(bus.level_num), 2);
        chk("game_over score", int'(bus.score), 1);
        step(1, 0, 1, 0, 0, 0);
        chk("game_over restart state", int'(bus.state), 1);
        chk("game_over restart lives", int'(bus.lives), 3);
        chk("game_over restart score", int'(bus.score), 0);
        chk("game_over restart level", int'(bus.level_num), 1);
        chk("game_over restart flag", int'(bus.game_over), 0);

        // Logout mid-PLAY at level 5, then verdicts while in IDLE.
        sc = 0;
        for (int k = 1; k <= 4; k++) begin
            win_round(k, sc);
            sc += k;
        end
        step(1, 0, 1, 0, 0, 0);
        chk("pre-logout level", int'(bus.level_num), 5);
        step(1, 1, 0, 0, 0, 0);
        chk("logout state", int'(bus.state), 0);
        chk("logout round_abort", int'(bus.round_abort), 1);
        chk("logout level", int'(bus.level_num), 1);
        chk("logout lives", int'(bus.lives), 3);
        chk("logout score", int'(bus.score), 0);
        chk("logout game_enable", int'(bus.game_enable), 0);
        step(0, 0, 0, 1, 0, 0);
        chk("idle win state", int'(bus.state), 0);
        chk("idle win abort cleared", int'(bus.round_abort), 0);
        chk("idle win level/score", int'({bus.level_num, bus.score}), int'({4'd1, 8'd0}));
        step(0, 0, 0, 0, 1, 1);
        chk("idle loose lives", int'(bus.lives), 3);

        // Auth drop during PLAY aborts the round.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("auth drop state", int'(bus.state), 0);
        chk("auth drop round_abort", int'(bus.round_abort), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("auth drop abort single", int'(bus.round_abort), 0);

        // Asynchronous reset mid-round.
        step(1, 0, 0, 0, 0, 0);
        win_round(1, 0);
        step(1, 0, 1, 0, 0, 0);
        chk("pre-reset game_enable", int'(bus.game_enable), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset state", int'(bus.state), 0);
        chk("async reset level", int'(bus.level_num), 1);
        chk("async reset score", int'(bus.score), 0);
        chk("async reset game_enable", int'(bus.game_enable), 0);
        chk("async reset round_abort", int'(bus.round_abort), 0);
        @(posedge clock);
        #1;
        chk("reset held round_abort", int'(bus.round_abort), 0);
        @(negedge clock);
        rst = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        chk("post-reset ready", int'(bus.state), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
